// File: rtl/spike_popcnt_sched_if.sv
// Bus bundle for the spike popcount row scheduler: job request, spike-buffer
// read port, popcount pipeline link and row-result handshake.
interface spike_popcnt_sched_if #(
  parameter int ADDR_W = 10,
  parameter int SUM_W  = ADDR_W + 6
);
  // job request
  logic              i_start;
  logic [ADDR_W-1:0] i_base_addr;
  logic [ADDR_W-1:0] i_word_num;
  logic              o_busy;
  // spike-buffer read port (1-cycle read latency)
  logic              o_rd_en;
  logic [ADDR_W-1:0] o_rd_addr;
  logic [31:0]       i_rd_data;
  // popcount pipeline link; the sum is six bits wide so a full word (32) fits
  logic [31:0]       o_Spikesdata;
  logic              o_Spikesdata_valid;
  logic [5:0]        i_SpikeSum;
  logic              i_SpikeSum_valid;
  // row result handshake
  logic [SUM_W-1:0]  o_RowSum;
  logic              o_RowSum_valid;
  logic              i_RowSum_ready;
  logic              o_done;

  // scheduler side
  modport slave (
    input  i_start, i_base_addr, i_word_num, i_rd_data, i_SpikeSum,
           i_SpikeSum_valid, i_RowSum_ready,
    output o_busy, o_rd_en, o_rd_addr, o_Spikesdata, o_Spikesdata_valid,
           o_RowSum, o_RowSum_valid, o_done
  );

  // job issuer / memory / pipeline side
  modport master (
    output i_start, i_base_addr, i_word_num, i_rd_data, i_SpikeSum,
           i_SpikeSum_valid, i_RowSum_ready,
    input  o_busy, o_rd_en, o_rd_addr, o_Spikesdata, o_Spikesdata_valid,
           o_RowSum, o_RowSum_valid, o_done
  );
endinterface

// File: rtl/spike_popcnt_sched.sv
// Spike popcount row scheduler: streams word_num spike words of one row out
// of the spike buffer into the popcount pipeline, sums the returning counts
// and presents the row total with a valid/ready handshake.
module spike_popcnt_sched #(
  parameter int ADDR_W = 10,
  parameter int SUM_W  = ADDR_W + 6
) (
  input logic                 s_clk,
  input logic                 s_rst_n,
  spike_popcnt_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [ADDR_W-1:0] word_num_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic [ADDR_W-1:0] issue_cnt_r;   // reads issued so far, including this cycle
  logic [ADDR_W-1:0] ret_cnt_r;     // popcount results received
  logic [SUM_W-1:0]  acc_r;
  logic              rd_en_r;
  logic              sd_valid_r;
  logic              row_valid_r;
  logic              done_r;
  logic              start_s;
  logic              sum_take_s;

  // A request only counts in IDLE; results only count while a job is in flight.
  assign start_s    = bus.i_start && (state_r == IDLE);
  assign sum_take_s = bus.i_SpikeSum_valid && ((state_r == FETCH) || (state_r == DRAIN));

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.i_start) begin
          if (bus.i_word_num != {ADDR_W{1'b0}}) state_s = FETCH;
          else                                  state_s = OUT;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        if (issue_cnt_r == word_num_r) state_s = DRAIN;
        else                           state_s = FETCH;
      end
      DRAIN: begin
        if (ret_cnt_r == word_num_r) state_s = OUT;
        else                         state_s = DRAIN;
      end
      OUT: begin
        if (bus.i_RowSum_ready) state_s = IDLE;
        else                    state_s = OUT;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) state_r <= IDLE;
    else          state_r <= state_s;
  end

  // Job parameters and read-address generation; the address wraps naturally.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      word_num_r  <= {ADDR_W{1'b0}};
      rd_addr_r   <= {ADDR_W{1'b0}};
      issue_cnt_r <= {ADDR_W{1'b0}};
    end else if (start_s) begin
      word_num_r  <= bus.i_word_num;
      rd_addr_r   <= bus.i_base_addr;
      issue_cnt_r <= ADDR_W'(1);
    end else if ((state_r == FETCH) && (state_s == FETCH)) begin
      rd_addr_r   <= rd_addr_r + ADDR_W'(1);
      issue_cnt_r <= issue_cnt_r + ADDR_W'(1);
    end
  end

  // Row accumulator and return counter, cleared when a job is accepted.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      acc_r     <= {SUM_W{1'b0}};
      ret_cnt_r <= {ADDR_W{1'b0}};
    end else if (start_s) begin
      acc_r     <= {SUM_W{1'b0}};
      ret_cnt_r <= {ADDR_W{1'b0}};
    end else if (sum_take_s) begin
      acc_r     <= acc_r + {{(SUM_W-6){1'b0}}, bus.i_SpikeSum};
      ret_cnt_r <= ret_cnt_r + ADDR_W'(1);
    end
  end

  // Registered strobes: read enable follows FETCH, data-valid trails it by the
  // memory latency, result-valid follows OUT, done marks the accept cycle.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      rd_en_r     <= 1'b0;
      sd_valid_r  <= 1'b0;
      row_valid_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      rd_en_r     <= (state_s == FETCH);
      sd_valid_r  <= rd_en_r;
      row_valid_r <= (state_s == OUT);
      done_r      <= (state_r == OUT) && bus.i_RowSum_ready;
    end
  end

  assign bus.o_busy             = (state_r != IDLE);
  assign bus.o_rd_en            = rd_en_r;
  assign bus.o_rd_addr          = rd_addr_r;
  // Read data already lands one cycle after the strobe; gate it so the word
  // bus is quiet whenever it is not qualified (including during reset).
  assign bus.o_Spikesdata       = sd_valid_r ? bus.i_rd_data : 32'h0000_0000;
  assign bus.o_Spikesdata_valid = sd_valid_r;
  assign bus.o_RowSum           = acc_r;
  assign bus.o_RowSum_valid     = row_valid_r;
  assign bus.o_done             = done_r;

endmodule

// File: tb/tb_spike_popcnt_sched.sv
// Bench for spike_popcnt_sched: models the 1-cycle spike buffer and the
// 3-cycle popcount pipeline, runs a table of row jobs and a few sequences.
module tb_spike_popcnt_sched;
  localparam int ADDR_W = 10;
  localparam int SUM_W  = 16;

  logic s_clk     = 1'b0;
  logic s_rst_n   = 1'b1;
  logic model_clr = 1'b1;

  // free-running clock
  always #5 s_clk = ~s_clk;

  spike_popcnt_sched_if #(.ADDR_W(ADDR_W), .SUM_W(SUM_W)) bus ();

  spike_popcnt_sched #(.ADDR_W(ADDR_W), .SUM_W(SUM_W)) dut (
    .s_clk   (s_clk),
    .s_rst_n (s_rst_n),
    .bus     (bus)
  );

  logic [31:0] mem [1024];
  logic [5:0]  p_sum [3];
  logic [2:0]  p_v;

  // spike buffer (1-cycle read) and popcount pipeline (3 stages, not reset by s_rst_n)
  always @(posedge s_clk) begin
    bus.i_rd_data <= mem[bus.o_rd_addr];
    p_sum[0]      <= 6'($countones(bus.o_Spikesdata));
    p_sum[1]      <= p_sum[0];
    p_sum[2]      <= p_sum[1];
    if (model_clr) p_v <= 3'b000;
    else           p_v <= {p_v[1:0], bus.o_Spikesdata_valid};
  end
  assign bus.i_SpikeSum       = p_sum[2];
  assign bus.i_SpikeSum_valid = p_v[2];

  typedef struct {
    logic [9:0]       base;
    logic [9:0]       n;
    logic [3:0][31:0] pat;      // word k of the row is pat[k % 4]
    int               exp_sum;
    int               exp_lat;  // cycle of first o_RowSum_valid, start = cycle 0
  } vec_t;

  vec_t vecs [6];
  int checks   = 0;
  int failures = 0;

  function automatic vec_t mkvec(input logic [9:0] base, input logic [9:0] n,
                                 input logic [31:0] p0, input logic [31:0] p1,
                                 input logic [31:0] p2, input logic [31:0] p3,
                                 input int exp_sum, input int exp_lat);
    vec_t v;
    v.base = base; v.n = n; v.pat = {p3, p2, p1, p0};
    v.exp_sum = exp_sum; v.exp_lat = exp_lat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Issue a job at the current negedge (cycle 0) and follow it to o_RowSum_valid.
  task automatic run_job(input string nm, input logic [9:0] base, input logic [9:0] n,
                         input logic [3:0][31:0] pat, input int exp_sum, input int exp_lat);
    int rd_cnt = 0, sv_cnt = 0, addr_err = 0, data_err = 0, vcyc = -1;
    logic [9:0] ea;
    for (int k = 0; k < int'(n); k++) begin
      ea = base + 10'(k);
      mem[ea] = pat[k % 4];
    end
    bus.i_base_addr = base;
    bus.i_word_num  = n;
    bus.i_start     = 1'b1;
    for (int c = 1; (c <= int'(n) + 20) && (vcyc < 0); c++) begin
      @(negedge s_clk);
      bus.i_start = 1'b0;
      if (bus.o_rd_en) begin
        ea = base + 10'(rd_cnt);
        if (bus.o_rd_addr !== ea) addr_err++;
        rd_cnt++;
      end
      if (bus.o_Spikesdata_valid) begin
        if (bus.o_Spikesdata !== pat[sv_cnt % 4]) data_err++;
        sv_cnt++;
      end
      if (bus.o_RowSum_valid) vcyc = c;
    end
    chk({nm, "_latency"},  64'(vcyc),         64'(exp_lat));
    chk({nm, "_rd_count"}, 64'(rd_cnt),       64'(n));
    chk({nm, "_rd_addr"},  64'(addr_err),     64'd0);
    chk({nm, "_sd_count"}, 64'(sv_cnt),       64'(n));
    chk({nm, "_sd_data"},  64'(data_err),     64'd0);
    chk({nm, "_rowsum"},   64'(bus.o_RowSum), 64'(exp_sum));
    chk({nm, "_busy"},     64'(bus.o_busy),   64'd1);
  endtask

  // Accept the result; with chain set, return in the done cycle for a back-to-back start.
  task automatic accept(input string nm, input bit chain);
    bus.i_RowSum_ready = 1'b1;
    @(negedge s_clk);
    bus.i_RowSum_ready = 1'b0;
    chk({nm, "_done"},      64'(bus.o_done),         64'd1);
    chk({nm, "_busy_idle"}, 64'(bus.o_busy),         64'd0);
    chk({nm, "_valid_off"}, 64'(bus.o_RowSum_valid), 64'd0);
    if (!chain) begin
      @(negedge s_clk);
      chk({nm, "_done_pulse"}, 64'(bus.o_done), 64'd0);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({bus.o_busy, bus.o_rd_en, bus.o_rd_addr, bus.o_Spikesdata,
                bus.o_Spikesdata_valid, bus.o_RowSum, bus.o_RowSum_valid, bus.o_done});
  endfunction

  // main sequence
  initial begin
    int stable_err = 0, done_err = 0, rd_err = 0;
    bus.i_start = 1'b0; bus.i_base_addr = 10'd0; bus.i_word_num = 10'd0;
    bus.i_RowSum_ready = 1'b0;
    for (int a = 0; a < 1024; a++) mem[a] = 32'h0;

    vecs[0] = mkvec(10'd0,    10'd4,    32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h8000_0001, 35,    10);
    vecs[1] = mkvec(10'd20,   10'd0,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0,     1);
    vecs[2] = mkvec(10'd1022, 10'd4,    32'h0000_000F, 32'h0000_00FF, 32'h0000_0003, 32'hF000_0000, 18,    10);
    vecs[3] = mkvec(10'd100,  10'd1,    32'hAAAA_AAAA, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 16,    7);
    vecs[4] = mkvec(10'd200,  10'd7,    32'h1234_5678, 32'h0000_0000, 32'hFFFF_0000, 32'h0000_0001, 59,    13);
    vecs[5] = mkvec(10'd5,    10'd1023, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32736, 1029);

    #2 s_rst_n = 1'b0;
    repeat (3) @(negedge s_clk);
    chk("reset_outputs", all_outs(), 64'd0);
    s_rst_n   = 1'b1;
    model_clr = 1'b0;
    @(negedge s_clk);

    for (int i = 0; i < 6; i++) begin
      run_job($sformatf("vec%0d", i), vecs[i].base, vecs[i].n, vecs[i].pat,
              vecs[i].exp_sum, vecs[i].exp_lat);
      accept($sformatf("vec%0d", i), 1'b0);
    end

    // result held while ready stays low; a start in OUT must be ignored
    run_job("hold", 10'd50, 10'd3, {32'h0, 32'hF, 32'hF, 32'hF}, 12, 9);
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin
        bus.i_base_addr = 10'd700; bus.i_word_num = 10'd5; bus.i_start = 1'b1;
      end else begin
        bus.i_start = 1'b0;
      end
      @(negedge s_clk);
      if (!bus.o_RowSum_valid || (bus.o_RowSum !== 16'd12)) stable_err++;
      if (bus.o_done)  done_err++;
      if (bus.o_rd_en) rd_err++;
    end
    bus.i_start = 1'b0;
    chk("hold_stable",   64'(stable_err), 64'd0);
    chk("hold_no_done",  64'(done_err),   64'd0);
    chk("hold_no_start", 64'(rd_err),     64'd0);
    accept("hold", 1'b1);
    // back-to-back: start issued in the done cycle
    run_job("b2b", 10'd300, 10'd2, {32'h0, 32'h0, 32'h7, 32'h3}, 5, 8);
    accept("b2b", 1'b0);

    // asynchronous reset in the middle of FETCH
    for (int k = 0; k < 8; k++) mem[400 + k] = 32'hFFFF_FFFF;
    bus.i_base_addr = 10'd400; bus.i_word_num = 10'd8; bus.i_start = 1'b1;
    @(negedge s_clk);
    bus.i_start = 1'b0;
    @(negedge s_clk);
    @(negedge s_clk);
    chk("midjob_fetching", 64'(bus.o_rd_en), 64'd1);
    #2 s_rst_n = 1'b0;
    #1 chk("midjob_async_reset", all_outs(), 64'd0);
    @(negedge s_clk);
    @(negedge s_clk);
    s_rst_n = 1'b1;
    repeat (6) @(negedge s_clk);
    chk("stale_sums_ignored", all_outs(), 64'd0);
    run_job("after_reset", 10'd600, 10'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, 64, 8);
    accept("after_reset", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
